mcu_link_router: RTL



---
 rtl/mcu_link_router_if.sv | 33 +++
 rtl/mcu_link_router.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mcu_link_router_if.sv
// mcu_link_router_if
//   Bundles the MCU byte channel and the shared command-target bus around
//   mcu_link_router.
//   MCU side    : in_strobe, in_start, in_data (to router); out_data (from router)
//   Target side : tgt_strobe[NTGT], tgt_start, tgt_data (to targets);
//                 tgt_dout[NTGT*8], tgt_irq[NTGT] (from targets)
//   Interrupt   : irq_n (active-low, to MCU)
//   Modports    : slave  = router view
//                 master = view of the MCU/targets that surround the router
interface mcu_link_router_if #(
  parameter int NTGT = 4
) ();
  logic                 in_strobe;
  logic                 in_start;
  logic [7:0]           in_data;
  logic [7:0]           out_data;
  logic [NTGT-1:0]      tgt_strobe;
  logic                 tgt_start;
  logic [7:0]           tgt_data;
  logic [NTGT*8-1:0]    tgt_dout;
  logic [NTGT-1:0]      tgt_irq;
  logic                 irq_n;

  modport slave (
    input  in_strobe, in_start, in_data, tgt_dout, tgt_irq,
    output out_data, tgt_strobe, tgt_start, tgt_data, irq_n
  );

  modport master (
    output in_strobe, in_start, in_data, tgt_dout, tgt_irq,
    input  out_data, tgt_strobe, tgt_start, tgt_data, irq_n
  );
endinterface

// File: rtl/mcu_link_router.sv
// mcu_link_router
//   Shares the single MCU byte channel between NTGT byte-command targets.
//   The header byte of a transfer picks a target (id < NTGT), the router's
//   own register page (SELF_ID) or nothing (bad id -> DISCARD, counted in
//   err_cnt). Data bytes of a routed transfer are forwarded one cycle later
//   as a one-hot strobe; the selected target's data_out is returned on
//   out_data. Per-target interrupts are masked and merged into irq_n.
//   Ports:
//     clk, reset : clock, synchronous active-high reset
//     link       : mcu_link_router_if.slave (MCU channel + target bus + irq_n)
//     busy       : high while a transfer is open (state != IDLE)
//     err_cnt    : saturating count of bad headers and timeouts
//   Optional: define MCU_LINK_TIMEOUT_EN to abort open transfers after
//   TIMEOUT cycles without a strobe.
module mcu_link_router #(
  parameter int          NTGT    = 4,
  parameter logic [7:0]  SELF_ID = 8'hFF,
  parameter logic [31:0] TIMEOUT = 32'd2_700_000
) (
  input  logic                clk,
  input  logic                reset,
  mcu_link_router_if.slave    link,
  output logic                busy,
  output logic [7:0]          err_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ROUTE,
    SELF,
    DISCARD
  } state_e;

  localparam logic [7:0] NTGT8 = 8'(NTGT);

  state_e          state_q;
  logic [2:0]      sel_q;
  logic            first_q;
  logic            self_byte0_q;
  logic [NTGT-1:0] irq_mask_q;
  logic [7:0]      out_data_q;
  logic [NTGT-1:0] tgt_strobe_q;
  logic            tgt_start_q;
  logic [7:0]      tgt_data_q;
  logic            irq_n_q;
  logic [7:0]      err_cnt_q;

  logic            hdr;
  logic            dat;
  logic [7:0]      dout_sel;
  logic [NTGT-1:0] sel_onehot;
  logic [NTGT-1:0] pend_bits;
  logic [7:0]      pend_byte;

  assign hdr       = link.in_strobe & link.in_start;
  assign dat       = link.in_strobe & ~link.in_start;
  assign pend_bits = link.tgt_irq & irq_mask_q;

  always_comb begin
    dout_sel   = '0;
    sel_onehot = '0;
    pend_byte  = '0;
    pend_byte[NTGT-1:0] = pend_bits;
    for (int unsigned i = 0; i < NTGT; i++) begin
      if (sel_q == i[2:0]) begin
        dout_sel      = link.tgt_dout[8*i +: 8];
        sel_onehot[i] = 1'b1;
      end
    end
  end

`ifdef MCU_LINK_TIMEOUT_EN
  logic [31:0] timer_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      first_q      <= 1'b0;
      self_byte0_q <= 1'b0;
      irq_mask_q   <= '1;
      out_data_q   <= '0;
      tgt_strobe_q <= '0;
      tgt_start_q  <= 1'b0;
      tgt_data_q   <= '0;
      irq_n_q      <= 1'b1;
      err_cnt_q    <= '0;
`ifdef MCU_LINK_TIMEOUT_EN
      timer_q      <= TIMEOUT;
`endif
    end else begin
      tgt_strobe_q <= '0;
      tgt_start_q  <= 1'b0;
      irq_n_q      <= ~|pend_bits;

      // out_data follows the state the byte arrived in, not the next state.
      case (state_q)
        IDLE:    out_data_q <= 8'h00;
        ROUTE:   out_data_q <= dout_sel;
        DISCARD: out_data_q <= 8'hFF;
        SELF:    if (dat) out_data_q <= pend_byte;
        default: out_data_q <= 8'h00;
      endcase

      if (hdr) begin
        // A header always closes the current transfer; only a bad id counts.
        if (link.in_data < NTGT8) begin
          sel_q   <= link.in_data[2:0];
          first_q <= 1'b1;
          state_q <= ROUTE;
        end else if (link.in_data == SELF_ID) begin
          self_byte0_q <= 1'b1;
          state_q      <= SELF;
        end else begin
          state_q   <= DISCARD;
          err_cnt_q <= (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
        end
      end else if (dat) begin
        case (state_q)
          ROUTE: begin
            tgt_strobe_q <= sel_onehot;
            tgt_data_q   <= link.in_data;
            tgt_start_q  <= first_q;
            first_q      <= 1'b0;
          end
          SELF: begin
            if (self_byte0_q) begin
              irq_mask_q   <= link.in_data[NTGT-1:0];
              self_byte0_q <= 1'b0;
            end
          end
          default: ;
        endcase
      end

`ifdef MCU_LINK_TIMEOUT_EN
      // Any strobe reloads, so a strobe landing on the expiry cycle wins.
      if (state_q == IDLE || link.in_strobe) begin
        timer_q <= TIMEOUT;
      end else if (timer_q == '0) begin
        state_q   <= IDLE;
        err_cnt_q <= (err_cnt_q == 8'hFF) ? 8'hFF : err_cnt_q + 8'd1;
      end else begin
        timer_q <= timer_q - 32'd1;
      end
`endif
    end
  end

  assign link.out_data   = out_data_q;
  assign link.tgt_strobe = tgt_strobe_q;
  assign link.tgt_start  = tgt_start_q;
  assign link.tgt_data   = tgt_data_q;
  assign link.irq_n      = irq_n_q;
  assign busy            = (state_q != IDLE);
  assign err_cnt         = err_cnt_q;

endmodule
